// File: rtl/ioctl_mem_packer.sv
// Generic synchronous FIFO with async reset; head is presented directly (show-ahead).
// Latency: a write at edge N is visible at the head after edge N when the FIFO was empty.
// Backpressure: in_vld while full is refused unless the head pops in the same cycle; refusal raises drop.
module ioctl_mem_packer_fifo #(
    parameter int W  = 42,
    parameter int AW = 3
) (
    input  logic         clk_sys,
    input  logic         reset_n,
    input  logic         in_vld,
    input  logic [W-1:0] in_dat,
    output logic         drop,
    output logic         out_vld,
    output logic [W-1:0] out_dat,
    input  logic         out_rdy
);
    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          push;
    logic          pop;

    // count never exceeds DEPTH, so its top bit alone flags full
    assign full    = count[AW];
    assign out_vld = (count != '0);
    assign pop     = out_vld & out_rdy;
    assign push    = in_vld & (~full | pop);
    assign drop    = in_vld & ~push;
    assign out_dat = mem[rd_ptr];

    always_ff @(posedge clk_sys) begin
        if (push) begin
            mem[wr_ptr] <= in_dat;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// Packs the ioctl download byte stream into 16-bit LE words with byte enables for a memory port.
// Latency: a byte strobe in cycle N reaches the FIFO head at edge N+1 once its word is complete or displaced.
// Backpressure: mem_req/mem_ack; a word arriving at a full FIFO is dropped and sets sticky overflow.
module ioctl_mem_packer #(
    parameter int          FIFO_AW     = 3,
    parameter logic [24:0] BASE_ADDR   = 25'd0,
    parameter logic [7:0]  MATCH_INDEX = 8'h00,
    parameter logic [7:0]  INDEX_MASK  = 8'h00
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        mem_req,
    output logic [23:0] mem_addr,
    output logic [15:0] mem_din,
    output logic [1:0]  mem_be,
    input  logic        mem_ack,
    output logic        busy,
    output logic        done,
    output logic        overflow
);
    typedef struct packed {
        logic [23:0] addr;
        logic [15:0] dat;
        logic [1:0]  be;
    } word_t;

    word_t       pend_q;
    logic        pend_vld;
    logic        download_d;
    logic        acc;
    logic [24:0] baddr;
    logic [23:0] waddr;
    logic        lane;
    logic [1:0]  lane_be;
    logic [15:0] lane_dat;
    logic        merge;
    logic        flush;
    logic        push_vld;
    word_t       push_dat;
    word_t       head_dat;
    logic        head_vld;
    logic        drop;
    logic        busy_nxt;

    assign acc      = ioctl_wr & ioctl_download &
                      (((ioctl_index ^ MATCH_INDEX) & INDEX_MASK) == 8'h00);
    assign baddr    = ioctl_addr + BASE_ADDR;
    assign waddr    = baddr[24:1];
    assign lane     = baddr[0];
    assign lane_be  = lane ? 2'b10 : 2'b01;
    assign lane_dat = lane ? {ioctl_dout, 8'h00} : {8'h00, ioctl_dout};

    // a second byte into the empty lane of the same word always completes it
    assign merge    = acc & pend_vld & (pend_q.addr == waddr) & ((pend_q.be & lane_be) == 2'b00);
    assign flush    = download_d & ~ioctl_download & pend_vld;

    always_comb begin
        push_vld = 1'b0;
        push_dat = pend_q;
        if (merge) begin
            push_vld     = 1'b1;
            push_dat.dat = pend_q.dat | lane_dat;
            push_dat.be  = pend_q.be | lane_be;
        end else if (acc || flush) begin
            push_vld = pend_vld;
        end
    end

    ioctl_mem_packer_fifo #(
        .W  ($bits(word_t)),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .in_vld  (push_vld),
        .in_dat  (push_dat),
        .drop    (drop),
        .out_vld (head_vld),
        .out_dat (head_dat),
        .out_rdy (mem_ack)
    );

    // head fields are gated so every output reads 0 while the FIFO is empty or in reset
    assign mem_req  = head_vld;
    assign mem_addr = head_vld ? head_dat.addr : 24'd0;
    assign mem_din  = head_vld ? head_dat.dat  : 16'd0;
    assign mem_be   = head_vld ? head_dat.be   : 2'b00;

    assign busy_nxt = ioctl_download | pend_vld | head_vld;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            pend_q     <= '0;
            pend_vld   <= 1'b0;
            download_d <= 1'b0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            download_d <= ioctl_download;
            if (merge || flush) begin
                pend_vld <= 1'b0;
            end else if (acc) begin
                pend_vld <= 1'b1;
                pend_q   <= {waddr, lane_dat, lane_be};
            end
            if (~download_d & ioctl_download) begin
                overflow <= 1'b0;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            busy <= busy_nxt;
            done <= busy & ~busy_nxt;
        end
    end
endmodule

// File: doc/ioctl_mem_packer.md
Name: ioctl_mem_packer

Overview:
- Sits directly downstream of the ARM->FPGA download stage. Consumes its byte stream (ioctl_download/ioctl_index/ioctl_wr/ioctl_addr/ioctl_dout) in the clk_sys domain.
- Packs bytes into 16-bit little-endian words with byte enables and buffers them in a small FIFO.
- Presents them to a 16-bit memory controller (SDRAM port) over a req/ack handshake, and reports when the download has fully drained to memory.

Parameters:
FIFO_AW, 3, log2 of FIFO depth (8 entries)
BASE_ADDR, 25'd0, byte offset added to ioctl_addr (25-bit wrap)
MATCH_INDEX, 8'h00, menu index accepted
INDEX_MASK, 8'h00, bits of ioctl_index compared; 0 = accept all

Ports:
clk_sys  in  1  system clock
reset_n  in  1  asynchronous active-low reset
ioctl_download  in  1  download active
ioctl_index  in  8  menu index of current download
ioctl_wr  in  1  one-cycle strobe, ioctl_addr/ioctl_dout valid
ioctl_addr  in  25  byte address
ioctl_dout  in  8  byte data
mem_req  out  1  FIFO head valid
mem_addr  out  24  word address of head
mem_din  out  16  data of head; [7:0] = even byte, [15:8] = odd byte
mem_be  out  2  byte enables of head; [0] = low byte
mem_ack  in  1  controller accepts head this cycle
busy  out  1  download active or data not yet retired
done  out  1  one-cycle pulse when busy falls
overflow  out  1  sticky: a word was dropped because the FIFO was full

Behaviour:
- Interface: one clock, clk_sys. Reset is reset_n, asynchronous and active-low.
- Reset values:
  - All outputs 0.
  - FIFO empty, pending invalid, download_d = 0.
  - Reset mid-operation discards all buffered data; mem_req drops immediately.
- Accept condition: ioctl_wr & ioctl_download & ((ioctl_index ^ MATCH_INDEX) & INDEX_MASK) == 0. Strobes failing this are ignored.
- Address: b = ioctl_addr + BASE_ADDR mod 2^25; word address w = b[24:1]; lane l = b[0].
- Pending register {pw[23:0], pd[15:0], pbe[1:0], pv}. At most one FIFO push per cycle. On an accepted byte:
  - pv and pw == w and pbe[l] == 0: merge byte into lane l. If pbe becomes 2'b11, push the merged word next cycle and clear pv.
  - Otherwise: if pv, push the old pending entry. Load the new byte into pending with pbe = one-hot lane l.
  - Rewrite of an already-filled lane (pv, pw == w, pbe[l] == 1): treated as "otherwise" — push the old entry, then start a new pending entry.
- End flush: download_d is ioctl_download registered. On download_d & ~ioctl_download, push pending if pv and clear pv.
- Start: on ~download_d & ioctl_download, clear overflow. Entries still in the FIFO keep draining.
- Push latency: the byte strobe in cycle N writes the FIFO at the N+1 edge. mem_req can be high from cycle N+1 when the FIFO was empty.
- FIFO:
  - Depth 2^FIFO_AW; each entry is {w, data, be}.
  - Outputs mem_addr/mem_din/mem_be are driven directly from the head entry.
  - mem_req = FIFO non-empty.
  - Head is retired on any cycle with mem_req & mem_ack. The next entry appears the following cycle.
  - Head fields are stable while mem_req is high and mem_ack is low.
  - mem_ack while mem_req is low is ignored.
- Full:
  - Push and pop in the same cycle while full succeeds; the count is unchanged.
  - Push while full without a pop: the entry is dropped and overflow is set.
  - Pointers wrap modulo depth; count uses FIFO_AW+1 bits.
- busy = ioctl_download | pv | mem_req, registered.
- done = one-cycle pulse on the cycle after busy goes 1 -> 0.

Test Plan:
1. Sequential download, BASE_ADDR 0, bytes 11,22,33,44 at addr 0..3, mem_ack tied 1 -> two requests: (addr 0, din 2211, be 11) and (addr 1, din 4433, be 11); then done pulse; overflow 0.
2. Odd length, 3 bytes AA,BB,CC at addr 0..2, then ioctl_download falls -> requests (0, BBAA, 11) and (1, 00CC or don't-care high byte, be 01) issued after the fall; busy drops after the final ack.
3. BASE_ADDR = 1, bytes 11,22,33 at addr 0..2 -> requests (0, 11xx, be 10) and (1, 3322, be 11).
4. Backpressure, FIFO_AW 3, mem_ack held 0, 20 bytes -> 8 entries held; overflow = 1 after the 9th word; mem_addr stable. Releasing ack yields words 0..7 in order. A new download rise clears overflow.
5. Index filter MATCH_INDEX 8'h02, INDEX_MASK 8'h3F, ioctl_index 8'h01 -> no requests, busy follows ioctl_download only. With ioctl_index 8'h42 -> bytes are accepted.
6. Reset asserted (reset_n = 0) with 4 entries queued and mem_req high -> mem_req, busy, overflow, done = 0 immediately. After release, the FIFO is empty and no stale request appears.
